// File: rtl/pcie_tx_os_scheduler.sv
// Transmit-side scheduler in front of phy_transmit: arbitrates LTSSM ordered sets, periodic SKP
// ordered sets and the DLL AXIS stream, switching owners only on packet/ordered-set boundaries.
module pcie_tx_os_scheduler #(
  parameter int DATA_WIDTH      = 32,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int USER_WIDTH      = 5,
  parameter int OS_WIDTH        = 32,
  parameter int SKP_INTERVAL    = 370,
  parameter int MAX_PENDING_SKP = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  link_up_i,
  input  logic                  skp_en_i,
  input  logic [OS_WIDTH-1:0]   skp_os_i,
  input  logic                  ltssm_os_valid_i,
  input  logic [OS_WIDTH-1:0]   ltssm_os_i,
  output logic                  ltssm_os_ready_o,
  output logic                  send_ordered_set_o,
  output logic [OS_WIDTH-1:0]   ordered_set_o,
  input  logic                  os_transmitted_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic [2:0]            skp_pending_o,
  output logic                  skp_overflow_o
);

  localparam int TW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SKP_INTERVAL - 1);
  localparam logic [2:0]    PEND_MAX   = 3'(MAX_PENDING_SKP);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OS   = 2'd1;
  localparam logic [1:0] ST_SKP  = 2'd2;
  localparam logic [1:0] ST_PKT  = 2'd3;

  logic [1:0]          state_r;
  logic [1:0]          state_next_s;
  logic [TW-1:0]       timer_r;
  logic [2:0]          pending_r;
  logic                overflow_r;
  logic                send_r;
  logic                ready_r;
  logic [OS_WIDTH-1:0] os_r;
  logic                wrap_s;
  logic                skp_done_s;
  logic                pkt_active_s;
  logic                pkt_end_s;

  assign wrap_s       = skp_en_i && (timer_r == TIMER_LAST);
  assign skp_done_s   = (state_r == ST_SKP) && os_transmitted_i;
  // A dropped link cuts the packet immediately; the DLL replays it later.
  assign pkt_active_s = (state_r == ST_PKT) && link_up_i;
  assign pkt_end_s    = pkt_active_s && s_axis_tvalid && m_axis_tready && s_axis_tlast;

  // Next-state arbitration: LTSSM OS > pending SKP > AXIS packet, only from IDLE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ltssm_os_valid_i) begin
          state_next_s = ST_OS;
        end else if (pending_r != 3'd0) begin
          state_next_s = ST_SKP;
        end else if (link_up_i && s_axis_tvalid) begin
          state_next_s = ST_PKT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_OS, ST_SKP: begin
        if (os_transmitted_i) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_PKT: begin
        if (!link_up_i || pkt_end_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_PKT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, ordered-set descriptor, send request and LTSSM accept pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      send_r  <= 1'b0;
      ready_r <= 1'b0;
      os_r    <= {OS_WIDTH{1'b0}};
    end else begin
      state_r <= state_next_s;
      ready_r <= 1'b0;
      if (state_r == ST_IDLE) begin
        if (ltssm_os_valid_i) begin
          os_r    <= ltssm_os_i;
          send_r  <= 1'b1;
          ready_r <= 1'b1;
        end else if (pending_r != 3'd0) begin
          os_r   <= skp_os_i;
          send_r <= 1'b1;
        end
      end else if (((state_r == ST_OS) || (state_r == ST_SKP)) && os_transmitted_i) begin
        send_r <= 1'b0;
      end
    end
  end

  // SKP interval timer, runs in every state while enabled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_r <= {TW{1'b0}};
    end else if (!skp_en_i || wrap_s) begin
      timer_r <= {TW{1'b0}};
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Pending-SKP count; a wrap coinciding with a SKP completion leaves it unchanged
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_r  <= 3'd0;
      overflow_r <= 1'b0;
    end else if (!skp_en_i) begin
      pending_r <= 3'd0;
    end else if (wrap_s && !skp_done_s) begin
      if (pending_r >= PEND_MAX) begin
        overflow_r <= 1'b1;
      end else begin
        pending_r <= pending_r + 3'd1;
      end
    end else if (skp_done_s && !wrap_s && (pending_r != 3'd0)) begin
      pending_r <= pending_r - 3'd1;
    end
  end

  assign ltssm_os_ready_o   = ready_r;
  assign send_ordered_set_o = send_r;
  assign ordered_set_o      = os_r;
  assign skp_pending_o      = pending_r;
  assign skp_overflow_o     = overflow_r;

  assign s_axis_tready = pkt_active_s && m_axis_tready;
  assign m_axis_tvalid = pkt_active_s && s_axis_tvalid;
  assign m_axis_tdata  = pkt_active_s ? s_axis_tdata : {DATA_WIDTH{1'b0}};
  assign m_axis_tkeep  = pkt_active_s ? s_axis_tkeep : {KEEP_WIDTH{1'b0}};
  assign m_axis_tlast  = pkt_active_s && s_axis_tlast;
  assign m_axis_tuser  = pkt_active_s ? s_axis_tuser : {USER_WIDTH{1'b0}};

endmodule

// File: tb/tb_pcie_tx_os_scheduler.sv
// Self-checking bench for pcie_tx_os_scheduler: directed scenarios plus random traffic,
// compared every cycle against a cycle-level reference model of the arbitration rules.
module tb_pcie_tx_os_scheduler;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 5;
  localparam int OW = 32;
  localparam int SI = 10;
  localparam int MP = 4;
  localparam logic [OW-1:0] SKP_OS = 32'h5C5C_0B0B;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i, link_up_i, skp_en_i, ltssm_os_valid_i, ltssm_os_ready_o;
  logic          send_ordered_set_o, os_transmitted_i;
  logic [OW-1:0] skp_os_i, ltssm_os_i, ordered_set_o;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [KW-1:0] s_axis_tkeep, m_axis_tkeep;
  logic [UW-1:0] s_axis_tuser, m_axis_tuser;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [2:0]    skp_pending_o;
  logic          skp_overflow_o;

  int total = 0;
  int bad = 0;

  // reference model: owner 0=idle 1=ltssm os 2=skp os 3=packet
  int            mo_owner, mo_run, mo_pend, mo_age;
  logic          mo_send, mo_rdy, mo_ovf;
  logic [OW-1:0] mo_os;

  pcie_tx_os_scheduler #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .OS_WIDTH(OW),
    .SKP_INTERVAL(SI), .MAX_PENDING_SKP(MP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .link_up_i(link_up_i), .skp_en_i(skp_en_i),
    .skp_os_i(skp_os_i), .ltssm_os_valid_i(ltssm_os_valid_i), .ltssm_os_i(ltssm_os_i),
    .ltssm_os_ready_o(ltssm_os_ready_o), .send_ordered_set_o(send_ordered_set_o),
    .ordered_set_o(ordered_set_o), .os_transmitted_i(os_transmitted_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .skp_pending_o(skp_pending_o), .skp_overflow_o(skp_overflow_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mo_owner = 0; mo_run = 0; mo_pend = 0; mo_age = 0;
    mo_send = 1'b0; mo_rdy = 1'b0; mo_ovf = 1'b0; mo_os = '0;
  endtask

  task automatic check_outputs();
    logic pass;
    pass = (mo_owner == 3) && link_up_i;
    chk("send_os", 64'(send_ordered_set_o), 64'(mo_send));
    chk("ordered_set", 64'(ordered_set_o), 64'(mo_os));
    chk("ltssm_ready", 64'(ltssm_os_ready_o), 64'(mo_rdy));
    chk("skp_pending", 64'(skp_pending_o), 64'(mo_pend));
    chk("skp_overflow", 64'(skp_overflow_o), 64'(mo_ovf));
    chk("m_tvalid", 64'(m_axis_tvalid), pass ? 64'(s_axis_tvalid) : 64'd0);
    chk("m_tdata", 64'(m_axis_tdata), pass ? 64'(s_axis_tdata) : 64'd0);
    chk("m_tkeep", 64'(m_axis_tkeep), pass ? 64'(s_axis_tkeep) : 64'd0);
    chk("m_tlast", 64'(m_axis_tlast), pass ? 64'(s_axis_tlast) : 64'd0);
    chk("m_tuser", 64'(m_axis_tuser), pass ? 64'(s_axis_tuser) : 64'd0);
    chk("s_tready", 64'(s_axis_tready), pass ? 64'(m_axis_tready) : 64'd0);
  endtask

  task automatic model_advance();
    bit   wrap, done, rdy;
    int   nowner;
    logic nsend;
    wrap   = skp_en_i && ((mo_run % SI) == SI - 1);
    done   = (mo_owner == 2) && os_transmitted_i;
    nowner = mo_owner;
    nsend  = mo_send;
    rdy    = 1'b0;
    case (mo_owner)
      0: begin
        if (ltssm_os_valid_i) begin
          nowner = 1; nsend = 1'b1; mo_os = ltssm_os_i; rdy = 1'b1;
        end else if (mo_pend > 0) begin
          nowner = 2; nsend = 1'b1; mo_os = skp_os_i;
        end else if (link_up_i && s_axis_tvalid) begin
          nowner = 3;
        end
      end
      1, 2: if (os_transmitted_i) begin nowner = 0; nsend = 1'b0; end
      3: if (!link_up_i || (s_axis_tvalid && m_axis_tready && s_axis_tlast)) nowner = 0;
      default: nowner = 0;
    endcase
    if (!skp_en_i) mo_pend = 0;
    else if (wrap && !done) begin
      if (mo_pend == MP) mo_ovf = 1'b1;
      else mo_pend++;
    end else if (done && !wrap && mo_pend > 0) mo_pend--;
    mo_run   = skp_en_i ? mo_run + 1 : 0;
    mo_age   = nsend ? mo_age + 1 : 0;
    mo_owner = nowner;
    mo_send  = nsend;
    mo_rdy   = rdy;
  endtask

  task automatic step();
    @(negedge clk_i);
    check_outputs();
    model_advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic phy(input int lat);
    os_transmitted_i = mo_send && (mo_age >= lat);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    model_reset();
    rst_i = 1'b0;
  endtask

  task automatic drain(input int lat);
    int n = 0;
    while ((mo_owner == 1 || mo_owner == 2) && n < 100) begin
      phy(lat);
      step();
      n++;
    end
    os_transmitted_i = 1'b0;
    chk("drain_bound", 64'(n < 100), 64'd1);
  endtask

  initial begin
    int   rises, n;
    logic prev;
    rst_i = 1'b1; link_up_i = 1'b0; skp_en_i = 1'b0; skp_os_i = SKP_OS;
    ltssm_os_valid_i = 1'b0; ltssm_os_i = '0; os_transmitted_i = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tuser = '0; m_axis_tready = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    rst_i = 1'b0;
    chk("rst_send", 64'(send_ordered_set_o), 64'd0);
    chk("rst_os", 64'(ordered_set_o), 64'd0);
    chk("rst_ready", 64'(ltssm_os_ready_o), 64'd0);
    chk("rst_pending", 64'(skp_pending_o), 64'd0);
    chk("rst_overflow", 64'(skp_overflow_o), 64'd0);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);

    // 1: idle link, SKP every SI cycles, completed after 3 cycles
    skp_en_i = 1'b1;
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 45; i++) begin
      phy(3);
      step();
      if (send_ordered_set_o && !prev) rises++;
      prev = send_ordered_set_o;
    end
    chk("t1_skp_count", 64'(rises), 64'd4);

    // 2: 4-beat packet with SKP wrap at beat 2
    skp_en_i = 1'b0;
    step();
    drain(1);
    skp_en_i = 1'b1; link_up_i = 1'b1; m_axis_tready = 1'b1;
    while ((mo_run % SI) != 7) step();
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
    step();
    for (int b = 0; b < 4; b++) begin
      s_axis_tdata = $urandom; s_axis_tkeep = 4'hF; s_axis_tuser = 5'($urandom);
      s_axis_tlast = (b == 3);
      step();
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    step();
    chk("t2_skp_send", 64'(send_ordered_set_o), 64'd1);
    chk("t2_skp_os", 64'(ordered_set_o), 64'(SKP_OS));

    // 3: LTSSM OS and pending SKP together, packet waiting
    drain(2);
    ltssm_os_i = 32'hA5A5_0001; ltssm_os_valid_i = 1'b1;
    step();
    ltssm_os_valid_i = 1'b0;
    repeat (12) step();
    ltssm_os_i = 32'hA5A5_0002; ltssm_os_valid_i = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tdata = $urandom;
    os_transmitted_i = 1'b1;
    step();
    os_transmitted_i = 1'b0;
    step();
    chk("t3_ltssm_ready", 64'(ltssm_os_ready_o), 64'd1);
    chk("t3_ltssm_os", 64'(ordered_set_o), 64'hA5A5_0002);
    ltssm_os_valid_i = 1'b0;
    drain(2);
    step();
    chk("t3_skp_next", 64'(ordered_set_o), 64'(SKP_OS));
    chk("t3_skp_send", 64'(send_ordered_set_o), 64'd1);
    n = 0;
    while (mo_owner != 3 && n < 60) begin
      phy(2);
      step();
      n++;
    end
    os_transmitted_i = 1'b0;
    chk("t3_pkt_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("t3_pkt_tready", 64'(s_axis_tready), 64'd1);
    step();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;

    // 4: completion withheld, pending saturates and overflow latches
    link_up_i = 1'b0;
    n = 0;
    while (mo_owner != 2 && n < 40) begin
      step();
      n++;
    end
    repeat (50) step();
    chk("t4_pending_sat", 64'(skp_pending_o), 64'd4);
    chk("t4_overflow", 64'(skp_overflow_o), 64'd1);
    drain(1);

    // 5: link drops while the sink stalls mid-packet
    skp_en_i = 1'b0;
    step();
    drain(1);
    link_up_i = 1'b1; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    step();
    step();
    m_axis_tready = 1'b0;
    step();
    link_up_i = 1'b0;
    step();
    chk("t5_s_tready", 64'(s_axis_tready), 64'd0);
    chk("t5_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    link_up_i = 1'b1; m_axis_tready = 1'b1;
    #1;
    chk("t5_idle_bubble", 64'(m_axis_tvalid), 64'd0);
    step();
    s_axis_tlast = 1'b1;
    step();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;

    // 6: reset while an ordered set is in progress
    skp_en_i = 1'b1;
    ltssm_os_i = 32'hA5A5_0003; ltssm_os_valid_i = 1'b1;
    step();
    ltssm_os_valid_i = 1'b0;
    repeat (12) step();
    chk("t6_pre_send", 64'(send_ordered_set_o), 64'd1);
    do_reset();
    chk("t6_send", 64'(send_ordered_set_o), 64'd0);
    chk("t6_pending", 64'(skp_pending_o), 64'd0);
    step();

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      link_up_i        = ($urandom % 16) != 0;
      skp_en_i         = ($urandom % 32) != 0;
      ltssm_os_valid_i = ($urandom % 10) == 0;
      ltssm_os_i       = $urandom;
      skp_os_i         = $urandom;
      s_axis_tvalid    = ($urandom % 4) != 0;
      s_axis_tlast     = ($urandom % 4) == 0;
      s_axis_tdata     = $urandom;
      s_axis_tkeep     = 4'($urandom);
      s_axis_tuser     = 5'($urandom);
      m_axis_tready    = ($urandom % 4) != 0;
      if (($urandom % 8) == 0) os_transmitted_i = 1'($urandom);
      else phy(int'($urandom_range(1, 4)));
      if (($urandom % 200) == 0) do_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
